// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter
// Two-requester arbiter for a shared 8-bit register bus. One requester is a
// Modbus front end that issues single-cycle request pulses. The other is a
// core that holds a valid/ready request. Requests are granted round-robin,
// and each granted request becomes exactly one bus strobe cycle. Reads wait
// one further cycle for the register bank's data.
//
// Optional feature: define ARB_WR_PROTECT_EN to reject Modbus writes whose
// address is >= PROT_BASE. A rejected write produces no bus_we and pulses
// m_werr instead. Without the macro, m_werr stays 0 and every write passes.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   m_addr, m_wdata            Modbus address / write data (valid with pulse)
//   m_read, m_write            Modbus request pulses (both high = write)
//   m_rdata, m_rvalid          Modbus read data and one-cycle valid
//   m_overrun                  request dropped because the slot was busy
//   m_werr                     protected write rejected (protect build only)
//   c_valid, c_we              core request and direction
//   c_addr, c_wdata            core address / write data
//   c_ready                    core acceptance pulse (its bus strobe cycle)
//   c_rdata, c_rvalid          core read data and one-cycle valid
//   bus_addr, bus_wdata        shared bus address / write data (held when idle)
//   bus_we, bus_re             shared bus strobes, one cycle each
//   bus_rdata                  bank read data, valid one cycle after bus_re
module reg_bus_arbiter #(
  parameter logic [7:0] PROT_BASE = 8'h80
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] m_addr,
  input  logic [7:0] m_wdata,
  input  logic       m_read,
  input  logic       m_write,
  output logic [7:0] m_rdata,
  output logic       m_rvalid,
  output logic       m_overrun,
  output logic       m_werr,
  input  logic       c_valid,
  input  logic       c_we,
  input  logic [7:0] c_addr,
  input  logic [7:0] c_wdata,
  output logic       c_ready,
  output logic [7:0] c_rdata,
  output logic       c_rvalid,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_wdata,
  output logic       bus_we,
  output logic       bus_re,
  input  logic [7:0] bus_rdata
);

  typedef enum logic [1:0] {ARB = 2'd0, ISSUE = 2'd1, RDWAIT = 2'd2} state_t;

  state_t     state;
  logic       pend;        // Modbus slot holds a request
  logic       pend_we;
  logic [7:0] pend_addr;
  logic [7:0] pend_wdata;
  logic       last_core;   // last grant went to the core
  logic       cur_core;    // owner of the in-flight transaction
  logic       cur_read;    // in-flight transaction needs RDWAIT

  logic m_pulse;
  logic grant;
  logic pick_core;
  logic m_grant;
  logic slot_free;
  logic protect_hit;

  assign m_pulse   = m_read | m_write;
  assign grant     = (state == ARB) && (pend || c_valid);
  // The core wins when it is the only requester, or when both are waiting
  // and Modbus had the previous grant.
  assign pick_core = c_valid && (!pend || !last_core);
  assign m_grant   = grant && !pick_core;
  // A Modbus grant empties the slot on this edge, so a pulse arriving on
  // the same edge can take the slot instead of being dropped.
  assign slot_free = !pend || m_grant;

`ifdef ARB_WR_PROTECT_EN
  assign protect_hit = pend_we && (pend_addr >= PROT_BASE);
`else
  assign protect_hit = 1'b0;
  // Keeps PROT_BASE referenced in the unprotected build.
  logic unused_prot_base;
  assign unused_prot_base = ^PROT_BASE;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB;
      pend       <= 1'b0;
      pend_we    <= 1'b0;
      pend_addr  <= 8'h00;
      pend_wdata <= 8'h00;
      last_core  <= 1'b1;
      cur_core   <= 1'b0;
      cur_read   <= 1'b0;
      m_rdata    <= 8'h00;
      m_rvalid   <= 1'b0;
      m_overrun  <= 1'b0;
      m_werr     <= 1'b0;
      c_ready    <= 1'b0;
      c_rdata    <= 8'h00;
      c_rvalid   <= 1'b0;
      bus_addr   <= 8'h00;
      bus_wdata  <= 8'h00;
      bus_we     <= 1'b0;
      bus_re     <= 1'b0;
    end else begin
      // Pulses default low; the grant and RDWAIT branches raise them.
      m_rvalid  <= 1'b0;
      c_rvalid  <= 1'b0;
      c_ready   <= 1'b0;
      m_werr    <= 1'b0;
      bus_we    <= 1'b0;
      bus_re    <= 1'b0;
      m_overrun <= m_pulse && !slot_free;

      if (m_pulse && slot_free) begin
        pend       <= 1'b1;
        pend_we    <= m_write;
        pend_addr  <= m_addr;
        pend_wdata <= m_wdata;
      end else if (m_grant) begin
        pend <= 1'b0;
      end

      case (state)
        ARB: begin
          if (grant) begin
            state     <= ISSUE;
            cur_core  <= pick_core;
            last_core <= pick_core;
            if (pick_core) begin
              bus_addr  <= c_addr;
              bus_wdata <= c_wdata;
              bus_we    <= c_we;
              bus_re    <= !c_we;
              cur_read  <= !c_we;
              c_ready   <= 1'b1;
            end else begin
              // A rejected write still consumes its ISSUE cycle and the
              // grant, but leaves the bus untouched.
              if (!protect_hit) begin
                bus_addr  <= pend_addr;
                bus_wdata <= pend_wdata;
              end
              bus_we   <= pend_we && !protect_hit;
              bus_re   <= !pend_we;
              cur_read <= !pend_we;
              m_werr   <= protect_hit;
            end
          end
        end
        ISSUE: begin
          state <= cur_read ? RDWAIT : ARB;
        end
        RDWAIT: begin
          state <= ARB;
          if (cur_core) begin
            c_rdata  <= bus_rdata;
            c_rvalid <= 1'b1;
          end else begin
            m_rdata  <= bus_rdata;
            m_rvalid <= 1'b1;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Self-checking bench for reg_bus_arbiter. A behavioural register bank
// answers bus reads with addr ^ 8'h4A one cycle after bus_re. A monitor logs
// every bus strobe and rvalid pulse. Each test pushes the transactions it
// expects (with the cycle they must appear in) and then compares them, in
// order, against the log.
module tb_reg_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] m_addr, m_wdata, m_rdata;
  logic       m_read, m_write, m_rvalid, m_overrun, m_werr;
  logic       c_valid, c_we, c_ready, c_rvalid;
  logic [7:0] c_addr, c_wdata, c_rdata;
  logic [7:0] bus_addr, bus_wdata, bus_rdata;
  logic       bus_we, bus_re;

  reg_bus_arbiter #(.PROT_BASE(8'h80)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_read(m_read), .m_write(m_write),
    .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_overrun(m_overrun), .m_werr(m_werr),
    .c_valid(c_valid), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_ready(c_ready), .c_rdata(c_rdata), .c_rvalid(c_rvalid),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register bank model.
  always @(posedge clk) bus_rdata <= bus_re ? (bus_addr ^ 8'h4A) : 8'hEE;

  logic [38:0] outs;
  assign outs = {m_rdata, m_rvalid, m_overrun, m_werr, c_ready, c_rdata, c_rvalid,
                 bus_addr, bus_wdata, bus_we, bus_re};

  typedef struct packed {
    logic        we;
    logic        re;
    logic [7:0]  addr;
    logic [7:0]  wdata;   // zero for reads
    logic        core;    // c_ready seen in the strobe cycle
    logic [31:0] cyc;
  } bus_ev_t;

  typedef struct packed {
    logic        core;
    logic [7:0]  data;
    logic [31:0] cyc;
  } rv_ev_t;

  bus_ev_t exp_bus[$];
  bus_ev_t obs_bus[$];
  rv_ev_t  exp_rv[$];
  rv_ev_t  obs_rv[$];
  int bus_rd = 0;
  int rv_rd = 0;
  int overrun_cnt = 0, overrun_cyc = -1;
  int werr_cnt = 0, werr_cyc = -1;
  int checks = 0, fails = 0;

  // Monitor: samples mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (bus_we || bus_re || c_ready)
      obs_bus.push_back(bus_ev_t'{bus_we, bus_re, bus_addr, (bus_we ? bus_wdata : 8'h00), c_ready, cyc});
    if (m_rvalid) obs_rv.push_back(rv_ev_t'{1'b0, m_rdata, cyc});
    if (c_rvalid) obs_rv.push_back(rv_ev_t'{1'b1, c_rdata, cyc});
    if (m_overrun) begin overrun_cnt++; overrun_cyc = cyc; end
    if (m_werr) begin werr_cnt++; werr_cyc = cyc; end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m_addr = 8'h00; m_wdata = 8'h00; m_read = 1'b0; m_write = 1'b0;
    c_valid = 1'b0; c_we = 1'b0; c_addr = 8'h00; c_wdata = 8'h00;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    idle_inputs();
    #2 rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (outs !== 39'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %h required 0", outs);
    end
    rst_n = 1'b1;
    repeat (2) tick();
    checks++;
    if (outs !== 39'd0) begin
      fails++;
      $display("FAIL idle_after_reset: got %h required 0", outs);
    end
    $display("test_reset done at cycle %0d", cyc);
  endtask

  task automatic test_modbus_read();
    int t;
    bus_ev_t eb, ob;
    rv_ev_t er, orv;
    tick(); t = cyc;
    m_read = 1'b1; m_addr = 8'h10;
    exp_bus.push_back(bus_ev_t'{1'b0, 1'b1, 8'h10, 8'h00, 1'b0, t + 2});
    exp_rv.push_back(rv_ev_t'{1'b0, 8'h5A, t + 4});
    tick(); m_read = 1'b0;
    repeat (6) tick();
    while (exp_bus.size() > 0) begin
      eb = exp_bus.pop_front(); ob = '0;
      if (bus_rd < obs_bus.size()) ob = obs_bus[bus_rd];
      bus_rd++; checks++;
      if (ob !== eb) begin
        fails++;
        $display("FAIL read_bus: got we=%b re=%b addr=%h core=%b cyc=%0d required we=%b re=%b addr=%h core=%b cyc=%0d",
                 ob.we, ob.re, ob.addr, ob.core, ob.cyc, eb.we, eb.re, eb.addr, eb.core, eb.cyc);
      end
    end
    while (exp_rv.size() > 0) begin
      er = exp_rv.pop_front(); orv = '0;
      if (rv_rd < obs_rv.size()) orv = obs_rv[rv_rd];
      rv_rd++; checks++;
      if (orv !== er) begin
        fails++;
        $display("FAIL read_rvalid: got core=%b data=%h cyc=%0d required core=%b data=%h cyc=%0d",
                 orv.core, orv.data, orv.cyc, er.core, er.data, er.cyc);
      end
    end
    checks++;
    if (bus_addr !== 8'h10 || bus_re !== 1'b0) begin
      fails++;
      $display("FAIL bus_addr_hold: got addr=%h re=%b required addr=10 re=0", bus_addr, bus_re);
    end
    checks++;
    if (obs_bus.size() != bus_rd || obs_rv.size() != rv_rd) begin
      fails++;
      $display("FAIL read_extra_events: got %0d/%0d required %0d/%0d", obs_bus.size(), obs_rv.size(), bus_rd, rv_rd);
    end
    bus_rd = obs_bus.size(); rv_rd = obs_rv.size();
    $display("test_modbus_read: read 0x10 issued at cycle %0d", t);
  endtask

  task automatic test_contention();
    int t;
    bus_ev_t eb, ob;
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    bus_rd = obs_bus.size(); rv_rd = obs_rv.size();
    tick(); t = cyc;
    m_write = 1'b1; m_addr = 8'h05; m_wdata = 8'h33;
    exp_bus.push_back(bus_ev_t'{1'b1, 1'b0, 8'h05, 8'h33, 1'b0, t + 2});
    exp_bus.push_back(bus_ev_t'{1'b1, 1'b0, 8'h06, 8'h44, 1'b1, t + 4});
    // Both requesters pending in the first arbitration cycle.
    tick();
    m_write = 1'b0;
    c_valid = 1'b1; c_we = 1'b1; c_addr = 8'h06; c_wdata = 8'h44;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (c_ready) c_valid = 1'b0;
    end
    c_valid = 1'b0;
    repeat (2) tick();
    while (exp_bus.size() > 0) begin
      eb = exp_bus.pop_front(); ob = '0;
      if (bus_rd < obs_bus.size()) ob = obs_bus[bus_rd];
      bus_rd++; checks++;
      if (ob !== eb) begin
        fails++;
        $display("FAIL contention_bus: got we=%b re=%b addr=%h wdata=%h core=%b cyc=%0d required we=%b re=%b addr=%h wdata=%h core=%b cyc=%0d",
                 ob.we, ob.re, ob.addr, ob.wdata, ob.core, ob.cyc, eb.we, eb.re, eb.addr, eb.wdata, eb.core, eb.cyc);
      end
    end
    checks++;
    if (obs_bus.size() != bus_rd) begin
      fails++;
      $display("FAIL contention_extra_strobes: got %0d required %0d", obs_bus.size(), bus_rd);
    end
    bus_rd = obs_bus.size();
    $display("test_contention: simultaneous writes started at cycle %0d", t);
  endtask

  task automatic test_overrun();
    int t, ov0;
    bus_ev_t eb, ob;
    rv_ev_t er, orv;
    ov0 = overrun_cnt;
    tick(); t = cyc;
    c_valid = 1'b1; c_we = 1'b0; c_addr = 8'h20;
    exp_bus.push_back(bus_ev_t'{1'b0, 1'b1, 8'h20, 8'h00, 1'b1, t + 1});
    exp_bus.push_back(bus_ev_t'{1'b0, 1'b1, 8'h30, 8'h00, 1'b0, t + 4});
    exp_rv.push_back(rv_ev_t'{1'b1, 8'h6A, t + 3});
    exp_rv.push_back(rv_ev_t'{1'b0, 8'h7A, t + 6});
    tick();                       // core ISSUE cycle
    c_valid = 1'b0; m_read = 1'b1; m_addr = 8'h30;
    tick();                       // slot now busy
    m_addr = 8'h31;
    tick(); m_read = 1'b0;
    repeat (6) tick();
    while (exp_bus.size() > 0) begin
      eb = exp_bus.pop_front(); ob = '0;
      if (bus_rd < obs_bus.size()) ob = obs_bus[bus_rd];
      bus_rd++; checks++;
      if (ob !== eb) begin
        fails++;
        $display("FAIL overrun_bus: got we=%b re=%b addr=%h core=%b cyc=%0d required we=%b re=%b addr=%h core=%b cyc=%0d",
                 ob.we, ob.re, ob.addr, ob.core, ob.cyc, eb.we, eb.re, eb.addr, eb.core, eb.cyc);
      end
    end
    while (exp_rv.size() > 0) begin
      er = exp_rv.pop_front(); orv = '0;
      if (rv_rd < obs_rv.size()) orv = obs_rv[rv_rd];
      rv_rd++; checks++;
      if (orv !== er) begin
        fails++;
        $display("FAIL overrun_rvalid: got core=%b data=%h cyc=%0d required core=%b data=%h cyc=%0d",
                 orv.core, orv.data, orv.cyc, er.core, er.data, er.cyc);
      end
    end
    checks++;
    if (overrun_cnt - ov0 != 1 || overrun_cyc != t + 3) begin
      fails++;
      $display("FAIL overrun_pulse: got count=%0d cyc=%0d required count=1 cyc=%0d", overrun_cnt - ov0, overrun_cyc, t + 3);
    end
    checks++;
    if (obs_bus.size() != bus_rd || obs_rv.size() != rv_rd) begin
      fails++;
      $display("FAIL overrun_extra_events: got %0d/%0d required %0d/%0d", obs_bus.size(), obs_rv.size(), bus_rd, rv_rd);
    end
    bus_rd = obs_bus.size(); rv_rd = obs_rv.size();
    $display("test_overrun: core read at cycle %0d, second Modbus read dropped", t);
  endtask

  task automatic test_round_robin();
    int t, ov0;
    bus_ev_t eb, ob;
    ov0 = overrun_cnt;
    tick(); t = cyc;
    c_valid = 1'b1; c_we = 1'b1; c_addr = 8'h40; c_wdata = 8'h11;
    m_write = 1'b1; m_addr = 8'h50; m_wdata = 8'hA0;
    for (int k = 0; k < 7; k++) begin
      if (k % 2 == 0)
        exp_bus.push_back(bus_ev_t'{1'b1, 1'b0, 8'h40, 8'h11, 1'b1, t + 1 + 4 * (k / 2)});
      else
        exp_bus.push_back(bus_ev_t'{1'b1, 1'b0, 8'h50 + 8'(k / 2), 8'hA0 + 8'(k / 2), 1'b0, t + 3 + 4 * (k / 2)});
    end
    for (int i = 1; i <= 16; i++) begin
      tick();
      m_write = (i == 3 || i == 6);
      m_addr  = 8'h50 + 8'(i / 3);
      m_wdata = 8'hA0 + 8'(i / 3);
      if (i == 13) c_valid = 1'b0;
    end
    while (exp_bus.size() > 0) begin
      eb = exp_bus.pop_front(); ob = '0;
      if (bus_rd < obs_bus.size()) ob = obs_bus[bus_rd];
      bus_rd++; checks++;
      if (ob !== eb) begin
        fails++;
        $display("FAIL round_robin_bus: got addr=%h wdata=%h core=%b cyc=%0d required addr=%h wdata=%h core=%b cyc=%0d",
                 ob.addr, ob.wdata, ob.core, ob.cyc, eb.addr, eb.wdata, eb.core, eb.cyc);
      end
    end
    checks++;
    if (overrun_cnt != ov0) begin
      fails++;
      $display("FAIL round_robin_overrun: got %0d required 0", overrun_cnt - ov0);
    end
    checks++;
    if (obs_bus.size() != bus_rd) begin
      fails++;
      $display("FAIL round_robin_extra_strobes: got %0d required %0d", obs_bus.size(), bus_rd);
    end
    bus_rd = obs_bus.size();
    $display("test_round_robin: alternating grants from cycle %0d", t);
  endtask

  task automatic test_write_protect();
    int t, t2, w0, w_exp;
    bus_ev_t eb, ob;
    w0 = werr_cnt;
    tick(); t = cyc;
    m_write = 1'b1; m_addr = 8'h80; m_wdata = 8'h99;
`ifdef ARB_WR_PROTECT_EN
    w_exp = 1;
`else
    w_exp = 0;
    exp_bus.push_back(bus_ev_t'{1'b1, 1'b0, 8'h80, 8'h99, 1'b0, t + 2});
`endif
    tick(); m_write = 1'b0;
    repeat (3) tick();
    tick(); t2 = cyc;
    m_write = 1'b1; m_addr = 8'h7F; m_wdata = 8'h66;
    exp_bus.push_back(bus_ev_t'{1'b1, 1'b0, 8'h7F, 8'h66, 1'b0, t2 + 2});
    tick(); m_write = 1'b0;
    repeat (4) tick();
    while (exp_bus.size() > 0) begin
      eb = exp_bus.pop_front(); ob = '0;
      if (bus_rd < obs_bus.size()) ob = obs_bus[bus_rd];
      bus_rd++; checks++;
      if (ob !== eb) begin
        fails++;
        $display("FAIL protect_bus: got we=%b addr=%h wdata=%h cyc=%0d required we=%b addr=%h wdata=%h cyc=%0d",
                 ob.we, ob.addr, ob.wdata, ob.cyc, eb.we, eb.addr, eb.wdata, eb.cyc);
      end
    end
    checks++;
    if (werr_cnt - w0 != w_exp || (w_exp == 1 && werr_cyc != t + 2)) begin
      fails++;
      $display("FAIL protect_werr: got count=%0d cyc=%0d required count=%0d cyc=%0d", werr_cnt - w0, werr_cyc, w_exp, t + 2);
    end
    checks++;
    if (obs_bus.size() != bus_rd) begin
      fails++;
      $display("FAIL protect_extra_strobes: got %0d required %0d", obs_bus.size(), bus_rd);
    end
    bus_rd = obs_bus.size();
    $display("test_write_protect: writes to 0x80 and 0x7F from cycle %0d", t);
  endtask

  task automatic test_reset_midop();
    int t, t2, rv0, ov0, w0;
    bus_ev_t eb, ob;
    rv_ev_t er, orv;
    tick(); t = cyc;
    m_read = 1'b1; m_addr = 8'h12;
    exp_bus.push_back(bus_ev_t'{1'b0, 1'b1, 8'h12, 8'h00, 1'b0, t + 2});
    tick(); m_read = 1'b0;
    tick();
    tick();                       // RDWAIT
    rst_n = 1'b0;
    #1;
    checks++;
    if (outs !== 39'd0) begin
      fails++;
      $display("FAIL midop_reset_outputs: got %h required 0", outs);
    end
    tick(); tick();
    rst_n = 1'b1;
    rv0 = obs_rv.size(); ov0 = overrun_cnt; w0 = werr_cnt;
    repeat (6) tick();
    checks++;
    if (obs_rv.size() != rv0 || overrun_cnt != ov0 || werr_cnt != w0) begin
      fails++;
      $display("FAIL midop_no_pulses: got rvalid=%0d overrun=%0d werr=%0d required 0 0 0",
               obs_rv.size() - rv0, overrun_cnt - ov0, werr_cnt - w0);
    end
    tick(); t2 = cyc;
    m_read = 1'b1; m_addr = 8'h13;
    exp_bus.push_back(bus_ev_t'{1'b0, 1'b1, 8'h13, 8'h00, 1'b0, t2 + 2});
    exp_rv.push_back(rv_ev_t'{1'b0, 8'h59, t2 + 4});
    tick(); m_read = 1'b0;
    repeat (6) tick();
    while (exp_bus.size() > 0) begin
      eb = exp_bus.pop_front(); ob = '0;
      if (bus_rd < obs_bus.size()) ob = obs_bus[bus_rd];
      bus_rd++; checks++;
      if (ob !== eb) begin
        fails++;
        $display("FAIL midop_bus: got we=%b re=%b addr=%h core=%b cyc=%0d required we=%b re=%b addr=%h core=%b cyc=%0d",
                 ob.we, ob.re, ob.addr, ob.core, ob.cyc, eb.we, eb.re, eb.addr, eb.core, eb.cyc);
      end
    end
    while (exp_rv.size() > 0) begin
      er = exp_rv.pop_front(); orv = '0;
      if (rv_rd < obs_rv.size()) orv = obs_rv[rv_rd];
      rv_rd++; checks++;
      if (orv !== er) begin
        fails++;
        $display("FAIL midop_rvalid: got core=%b data=%h cyc=%0d required core=%b data=%h cyc=%0d",
                 orv.core, orv.data, orv.cyc, er.core, er.data, er.cyc);
      end
    end
    checks++;
    if (obs_bus.size() != bus_rd || obs_rv.size() != rv_rd) begin
      fails++;
      $display("FAIL midop_extra_events: got %0d/%0d required %0d/%0d", obs_bus.size(), obs_rv.size(), bus_rd, rv_rd);
    end
    bus_rd = obs_bus.size(); rv_rd = obs_rv.size();
    $display("test_reset_midop: reset in RDWAIT at cycle %0d, recovery read at %0d", t + 3, t2);
  endtask

  initial begin
    test_reset();
    test_modbus_read();
    test_contention();
    test_overrun();
    test_round_robin();
    test_write_protect();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/reg_bus_arbiter.md
REG_BUS_ARBITER -- requirements
Module: reg_bus_arbiter

Interface
REQ-001 SHALL have parameter PROT_BASE, default 8'h80, lowest Modbus-protected register address (used only under REQ-031).
REQ-002 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports m_addr, m_wdata  input  8 each  Modbus-side address and write data, valid with strobe.
REQ-005 SHALL have ports m_read, m_write  input  1 each  Modbus single-cycle request pulses, no backpressure.
REQ-006 SHALL have ports m_rdata  output  8, m_rvalid  output  1  Modbus read data and one-cycle valid pulse.
REQ-007 SHALL have port m_overrun  output  1  one-cycle pulse when a Modbus request is dropped.
REQ-008 SHALL have port m_werr  output  1  one-cycle pulse when a protected write is rejected.
REQ-009 SHALL have ports c_valid, c_we  input  1 each, c_addr, c_wdata  input  8 each  core-side request.
REQ-010 SHALL have port c_ready  output  1  one-cycle acceptance pulse.
REQ-011 SHALL have ports c_rdata  output  8, c_rvalid  output  1  core read data and valid pulse.
REQ-012 SHALL have ports bus_addr, bus_wdata  output  8 each, bus_we, bus_re  output  1 each  shared register bus.
REQ-013 SHALL have port bus_rdata  input  8  register-bank read data, valid exactly one cycle after bus_re.

Function
REQ-014 SHALL latch a Modbus pulse (m_read or m_write) with its addr/data into one pending slot on the same clock edge.
REQ-015 SHALL drop a new Modbus pulse while the slot is pending, keep the old request, and pulse m_overrun one cycle later.
REQ-016 SHALL treat m_read and m_write high together as a write.
REQ-017 SHALL use FSM states ARB, ISSUE, RDWAIT; ARB -> ISSUE on any request; ISSUE -> RDWAIT on read, else ARB; RDWAIT -> ARB.
REQ-018 SHALL select in ARB, when only one requester is pending, that requester; when both are pending, the one not granted last (round-robin).
REQ-019 SHALL register bus_addr, bus_wdata, bus_we/bus_re at the ARB->ISSUE edge, so the strobe is high only during ISSUE, exactly one cycle.
REQ-020 SHALL sample c_addr, c_wdata and c_we at the ARB grant edge; the core SHALL hold them stable while c_valid is high.
REQ-021 SHALL pulse c_ready during the core's ISSUE cycle; c_valid still high on the following cycle counts as a new request.
REQ-022 SHALL clear the Modbus pending slot at the ARB->ISSUE edge when Modbus is granted; a pulse on that same edge SHALL be accepted.
REQ-023 SHALL capture bus_rdata at the RDWAIT exit edge into m_rdata or c_rdata and pulse the matching rvalid for one cycle.
REQ-024 SHALL give Modbus latency: pulse at cycle t, bus strobe at t+2, m_rvalid at t+4 when uncontended.
REQ-025 SHALL hold m_rdata/c_rdata until the next read for the same requester.
REQ-026 SHALL keep bus_addr/bus_wdata at their last values when idle; only strobes return to 0.
REQ-027 SHALL never assert bus_we and bus_re together and SHALL keep at least one idle (ARB) cycle between transactions.

Reset
REQ-028 SHALL on rst_n low asynchronously force state ARB, pending slot empty, last-grant = core, and zero on every output.
REQ-029 SHALL abandon an in-flight transaction on mid-operation reset with no rvalid, ready or error pulse after release.

Configuration
REQ-030 SHALL compile the write-protect feature only when macro ARB_WR_PROTECT_EN is defined.
REQ-031 SHALL, with ARB_WR_PROTECT_EN, make a granted Modbus write with m_addr >= PROT_BASE drive no bus_we, pulse m_werr in its ISSUE cycle, and count as a grant for round-robin; core writes are never protected.
REQ-032 SHALL, without ARB_WR_PROTECT_EN, tie m_werr to 0 and pass all Modbus writes.

Verification
REQ-033 SHALL cover: m_read addr 0x10 at t, bus_rdata=0x5A -> bus_re at t+2 with bus_addr=0x10, m_rvalid at t+4 with m_rdata=0x5A.
REQ-034 SHALL cover: m_write 0x05<-0x33 and core write 0x06<-0x44 in the same cycle after reset -> Modbus strobe first, core strobe later, c_ready with the core strobe.
REQ-035 SHALL cover: second m_read one cycle after the first, before its grant -> m_overrun pulse, only one bus_re for the first address.
REQ-036 SHALL cover: c_valid held continuously with Modbus pulses every 3 cycles -> bus grants alternate core/Modbus, no Modbus overruns.
REQ-037 SHALL cover: with ARB_WR_PROTECT_EN, m_write addr 0x80 -> no bus_we, m_werr pulse; addr 0x7F -> bus_we high, m_werr 0.
REQ-038 SHALL cover: rst_n low during RDWAIT -> all outputs 0, no m_rvalid after release, next m_read served normally.
